seq_shift_unit: RTL

- Parametrised multi-cycle shift/decrement unit for the MIPS datapath; successor to the fixed 32-bit combinational shift block.
- Adds selectable operation, programmable shift amount, configurable bits-per-cycle and a valid/ready handshake on both sides.
- Sits between the register-file read stage and write-back. The control FSM stalls on in_ready and out_valid.

---
 rtl/seq_shift_unit.sv | 79 +++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate/decrement unit with valid/ready on both sides
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_err,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2;
  logic [1:0]         state;
  logic [WIDTH-1:0]   work, sh, sra, imm;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] rem, k;
  logic               acc, n0, last;
  assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign busy     = state != IDLE;
  assign acc      = in_valid & in_ready;
  assign n0       = (in_shamt == '0) | (in_op > 3'd4);
  assign imm      = (in_op == 3'd5) ? in_data - WIDTH'(1) : in_data;
  // when STEP == WIDTH the truncated branch is unreachable since rem < WIDTH
  assign k        = (int'(rem) < STEP) ? rem : SHAMT_W'(STEP);
  assign last     = rem == k;
  assign sra      = $signed(work) >>> k;
  always_comb
    sh = (op == 3'd0) ? work << k :
         (op == 3'd1) ? work >> k :
         (op == 3'd2) ? sra :
         (op == 3'd3) ? (work << k) | (work >> (WIDTH - int'(k))) :
                        (work >> k) | (work << (WIDTH - int'(k)));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_err   <= 1'b0;
      rem       <= '0;
      work      <= '0;
      op        <= '0;
    end else if (acc & n0) begin
      state     <= HOLD;
      out_valid <= 1'b1;
      out_data  <= imm;
      out_zero  <= imm == '0;
      out_err   <= in_op[2] & in_op[1];
    end else if (acc) begin
      state     <= RUN;
      out_valid <= 1'b0;
      work      <= in_data;
      op        <= in_op;
      rem       <= in_shamt;
    end else if (state == RUN) begin
      work <= sh;
      rem  <= rem - k;
      if (last) begin
        state     <= HOLD;
        out_valid <= 1'b1;
        out_data  <= sh;
        out_zero  <= sh == '0;
        out_err   <= 1'b0;
      end
    end else if ((state == HOLD) & out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule
